// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: request/status handshake plus PS2 line levels and open-drain enables.
// The master side is the host system/environment; the slave side is ps2_host_tx.
interface ps2_host_tx_if;
    logic       start;
    logic [7:0] tx_data;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, tx_data, ps2_clk_in, ps2_data_in,
        input  ps2_clk_oe, ps2_data_oe, busy, done, err
    );

    modport slave (
        input  start, tx_data, ps2_clk_in, ps2_data_in,
        output ps2_clk_oe, ps2_data_oe, busy, done, err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS2 host-to-device command transmitter (inhibit, request, 8 data bits,
// odd parity, stop, device ack). All outputs are registered.
// Optional feature macro: PS2_TX_ACK_CHECK_EN -- when defined, a nack from the device
// ends the transfer with err instead of done.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave bus
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                        : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned FRAME_W = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [BIT_W-1:0]     w_bit_cnt_nxt;
    logic [BIT_W-1:0]     w_bit_idx;
    logic [FRAME_W-1:0]   r_frame;
    logic [FRAME_W-1:0]   w_frame_nxt;
    logic [15:0]          w_frame_ext;

    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_data_s1, r_data_s2;
    logic w_clk_fall;

    logic r_busy, r_done, r_err, r_clk_oe, r_data_oe;
    logic w_busy_nxt, w_done_nxt, w_err_nxt, w_clk_oe_nxt, w_data_oe_nxt;

`ifdef PS2_TX_ACK_CHECK_EN
    logic r_ack_ok;
    logic w_ack_ok_nxt;
`endif

    // Two-flop synchronizers on both PS2 lines plus a delayed clock sample for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
        end else begin
            r_clk_s1   <= bus.ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_data_s1  <= bus.ps2_data_in;
            r_data_s2  <= r_data_s1;
        end
    end

    assign w_clk_fall = r_clk_prev & ~r_clk_s2;

    // FSM state, counters, latched frame and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_frame   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
            r_ack_ok  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_frame   <= w_frame_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_data_oe <= w_data_oe_nxt;
`ifdef PS2_TX_ACK_CHECK_EN
            r_ack_ok  <= w_ack_ok_nxt;
`endif
        end
    end

    // Next-state logic; outputs are decoded from the next state so they register in step with it.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_frame_nxt   = r_frame;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_busy_nxt    = 1'b0;
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        w_bit_idx     = '0;
        w_frame_ext   = '1;
`ifdef PS2_TX_ACK_CHECK_EN
        w_ack_ok_nxt  = r_ack_ok;
`endif

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_frame_nxt = {~^bus.tx_data, bus.tx_data};
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    w_cnt_nxt     = '0;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = S_REQ;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_REQ, S_SHIFT, S_ACK, S_RELEASE: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Device stopped clocking (or never started): abandon the transfer.
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    case (r_state)
                        S_REQ, S_SHIFT: begin
                            if (w_clk_fall) begin
                                w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                                // Edge 10 is the stop bit: data is released and we await the ack edge.
                                w_state_nxt   = (r_bit_cnt == BIT_W'(9)) ? S_ACK : S_SHIFT;
                            end
                        end
                        S_ACK: begin
                            if (w_clk_fall) begin
                                w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
`ifdef PS2_TX_ACK_CHECK_EN
                                w_ack_ok_nxt  = ~r_data_s2;
`endif
                                w_state_nxt   = S_RELEASE;
                            end
                        end
                        S_RELEASE: begin
                            if (r_clk_s2 && r_data_s2) begin
                                w_cnt_nxt   = '0;
`ifdef PS2_TX_ACK_CHECK_EN
                                w_done_nxt  = r_ack_ok;
                                w_err_nxt   = ~r_ack_ok;
`else
                                w_done_nxt  = 1'b1;
`endif
                                w_state_nxt = S_IDLE;
                            end
                        end
                        default: w_state_nxt = S_IDLE;
                    endcase
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase

        // Output decode from next state; bit counts 1..9 select d0..d7 then parity.
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_clk_oe_nxt = (w_state_nxt == S_INHIBIT);
        w_bit_idx    = w_bit_cnt_nxt - BIT_W'(1);
        w_frame_ext  = {7'h7f, w_frame_nxt};
        case (w_state_nxt)
            S_INHIBIT: w_data_oe_nxt = (w_cnt_nxt == CNT_W'(INHIBIT_CYCLES - 1));
            S_REQ:     w_data_oe_nxt = 1'b1;
            S_SHIFT:   w_data_oe_nxt = ~w_frame_ext[w_bit_idx];
            default:   w_data_oe_nxt = 1'b0;
        endcase
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.ps2_clk_oe  = r_clk_oe;
    assign bus.ps2_data_oe = r_data_oe;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000, clk cycles the host holds PS2 clock low (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, clk cycles allowed from clock release to ack (20 ms at 100 MHz).
REQ-003 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to transmit tx_data.
REQ-006 tx_data  input  8  command byte to send to the device.
REQ-007 ps2_clk_in  input  1  PS2 clock line level, asynchronous.
REQ-008 ps2_data_in  input  1  PS2 data line level, asynchronous.
REQ-009 ps2_clk_oe  output  1  1 = pull PS2 clock low; 0 = release (open-drain).
REQ-010 ps2_data_oe  output  1  1 = pull PS2 data low; 0 = release.
REQ-011 busy  output  1  high from the cycle after start is accepted until the return to IDLE.
REQ-012 done  output  1  one-cycle pulse on successful completion.
REQ-013 err  output  1  one-cycle pulse on timeout or ack failure.

Function
REQ-014 ps2_clk_in and ps2_data_in SHALL each pass through a 2-flop synchronizer; a clock falling edge is synchronized stage-2 = 0 with the previous sample = 1.
REQ-015 States: IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE.
REQ-016 IDLE: busy=0, both oe=0; start=1 latches tx_data, computes odd parity (parity = ~^tx_data), and enters INHIBIT.
REQ-017 start SHALL be ignored outside IDLE; the latched byte SHALL NOT change during a transfer.
REQ-018 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe=1 in the last INHIBIT cycle; then REQ.
REQ-019 REQ: ps2_clk_oe=0, ps2_data_oe=1 (start bit 0); the timeout counter clears on entry.
REQ-020 Falling edges after REQ, counted by a 4-bit counter: edges 1-8 drive d0..d7 (LSB first), edge 9 drives parity, edge 10 releases data (stop bit); ps2_data_oe = ~bit.
REQ-021 On edge 10, the FSM SHALL enter ACK; on edge 11, it samples ps2_data_in: 0 = ack, 1 = nack.
REQ-022 RELEASE: wait until both synchronized lines read 1, then pulse done (ack) or err (nack) and return to IDLE in the same cycle.
REQ-023 If the timeout counter reaches TIMEOUT_CYCLES in REQ, SHIFT, ACK or RELEASE: both oe=0, err pulses, IDLE next cycle.
REQ-024 done and err SHALL never assert in the same cycle; only one pulse per accepted start.
REQ-025 Device clock edges seen in IDLE or INHIBIT SHALL be ignored.

Reset
REQ-026 rst=1 SHALL force IDLE, busy=0, done=0, err=0, ps2_clk_oe=0, ps2_data_oe=0, and clear the counters on the next clk edge.
REQ-027 Reset mid-transfer SHALL release both lines the next cycle with no done/err pulse; start asserted with rst SHALL be ignored.

Configuration
REQ-028 Macro PS2_TX_ACK_CHECK_EN: when defined, the ack bit is checked per REQ-021/022 and a nack gives err.
REQ-029 When PS2_TX_ACK_CHECK_EN is undefined, the ack bit SHALL still be clocked but ignored, and done SHALL pulse on every non-timeout completion.

Verification
REQ-030 Bench SHALL send start with tx_data=0xED from a device model -> data bits 1,0,1,1,0,1,1,1, parity 1, stop released, device ack -> done after RELEASE, err=0.
REQ-031 Bench SHALL send tx_data=0xF4 -> parity 0; tx_data=0x00 -> parity 1; bits match on device rising-edge sampling.
REQ-032 Bench SHALL measure clock low -> ps2_clk_oe=1 for exactly 10000 cycles with default parameters, and ps2_data_oe=1 on the final cycle.
REQ-033 With no device clocks after REQ -> err pulse at 2000000 cycles, both oe=0, busy=0 next cycle.
REQ-034 With the device returning nack (data=1 at edge 11) -> err with PS2_TX_ACK_CHECK_EN defined, done without it.
REQ-035 Bench SHALL assert rst after the 5th falling edge -> both lines released next cycle, no done/err; a second start during busy -> ignored, with only one transfer observed.
